// File: rtl/exp_arbiter_pkg.sv
// Shared definitions for the exponential-engine arbiter.
//   - state_t : controller state encoding
//   - INT_W / FRAC_W / X_W : engine operand and result widths
//   - CNT_W : width of the WAIT timeout counter
package exp_arbiter_pkg;

    localparam int INT_W  = 2;
    localparam int FRAC_W = 16;
    localparam int X_W    = 16;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector (purely combinational).
// Ports:
//   req0, req1 : pending requests
//   last       : id of the requester served most recently
//   id         : winning requester (valid only when valid=1)
//   valid      : at least one request is pending
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic id,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        // On a tie the requester not served last wins; otherwise the sole
        // requester wins regardless of history.
        if (req0 && req1) begin
            id = ~last;
        end else begin
            id = req1;
        end
    end

endmodule

// File: rtl/exp_arbiter.sv
// Arbitrates two requesters onto one exponential engine and returns the
// result through a valid/ack handshake, aborting a job whose engine never
// reports done within TIMEOUT_CYCLES WAIT cycles.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req0/req1, x0/x1         : requests and their operands
//   gnt0/gnt1                : one-cycle operand-accepted pulses
//   eng_x, eng_start         : operand and start pulse to the engine
//   eng_done, eng_intpart,
//   eng_fracpart             : engine done level and result
//   out_valid, out_ack       : result handshake
//   out_id, out_int,
//   out_frac, out_err        : result owner, value and timeout flag
module exp_arbiter
    import exp_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [X_W-1:0]    x0,
    input  logic [X_W-1:0]    x1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [X_W-1:0]    eng_x,
    output logic              eng_start,
    input  logic              eng_done,
    input  logic [INT_W-1:0]  eng_intpart,
    input  logic [FRAC_W-1:0] eng_fracpart,
    output logic              out_valid,
    input  logic              out_ack,
    output logic              out_id,
    output logic [INT_W-1:0]  out_int,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_err
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    state_t              state_q, state_d;
    logic                id_q, id_d;
    logic                last_q, last_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc;
    logic [INT_W-1:0]    int_q, int_d;
    logic [FRAC_W-1:0]   frac_q, frac_d;
    logic                err_q, err_d;

    logic                rr_id;
    logic                rr_valid;

    rr_arb2 u_rr (
        .req0  (req0),
        .req1  (req1),
        .last  (last_q),
        .id    (rr_id),
        .valid (rr_valid)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        int_d   = int_q;
        frac_d  = frac_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (rr_valid) begin
                    id_d    = rr_id;
                    x_d     = rr_id ? x1 : x0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                // eng_done may still be high from the previous job here, so
                // it is not looked at until WAIT.
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done is tested first so it wins over a simultaneous timeout
                if (eng_done) begin
                    int_d   = eng_intpart;
                    frac_d  = eng_fracpart;
                    err_d   = 1'b0;
                    state_d = ST_RESULT;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TMO) begin
                        int_d   = '0;
                        frac_d  = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESULT;
                    end
                end
            end
            ST_RESULT: begin
                if (out_ack) begin
                    last_d  = id_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            x_q     <= '0;
            cnt_q   <= '0;
            int_q   <= '0;
            frac_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
            frac_q  <= frac_d;
            err_q   <= err_d;
        end
    end

    assign eng_start = (state_q == ST_START);
    assign gnt0      = (state_q == ST_START) && !id_q;
    assign gnt1      = (state_q == ST_START) &&  id_q;
    assign eng_x     = x_q;
    assign out_valid = (state_q == ST_RESULT);
    assign out_id    = id_q;
    assign out_int   = int_q;
    assign out_frac  = frac_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_exp_arbiter.sv
// Self-checking bench for exp_arbiter: engine model, result scoreboard,
// a table of request patterns and hand-written multi-cycle sequences.
module tb_exp_arbiter;
    import exp_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, req1;
    logic [15:0] x0, x1;
    logic        gnt0, gnt1;
    logic [15:0] eng_x;
    logic        eng_start;
    logic        eng_done = 1'b1;
    logic [1:0]  eng_int  = 2'b11;
    logic [15:0] eng_frac = 16'hDEAD;
    logic        out_valid, out_ack, out_id, out_err;
    logic [1:0]  out_int;
    logic [15:0] out_frac;

    // second instance: short timeout, engine driven by hand
    logic        t_req0, t_req1;
    logic [15:0] t_x0, t_x1;
    logic        t_gnt0, t_gnt1, t_eng_start, t_eng_done;
    logic [15:0] t_eng_x;
    logic        t_out_valid, t_ack, t_out_id, t_out_err;
    logic [1:0]  t_out_int;
    logic [15:0] t_out_frac;

    exp_arbiter dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .x0(x0), .x1(x1),
        .gnt0(gnt0), .gnt1(gnt1), .eng_x(eng_x), .eng_start(eng_start),
        .eng_done(eng_done), .eng_intpart(eng_int), .eng_fracpart(eng_frac),
        .out_valid(out_valid), .out_ack(out_ack), .out_id(out_id),
        .out_int(out_int), .out_frac(out_frac), .out_err(out_err)
    );

    exp_arbiter #(.TIMEOUT_CYCLES(8)) u_to (
        .clk(clk), .rst(rst), .req0(t_req0), .req1(t_req1), .x0(t_x0), .x1(t_x1),
        .gnt0(t_gnt0), .gnt1(t_gnt1), .eng_x(t_eng_x), .eng_start(t_eng_start),
        .eng_done(t_eng_done), .eng_intpart(2'b11), .eng_fracpart(16'hBEEF),
        .out_valid(t_out_valid), .out_ack(t_ack), .out_id(t_out_id),
        .out_int(t_out_int), .out_frac(t_out_frac), .out_err(t_out_err)
    );

    // Engine model: done drops on start, rises 10 cycles later, int=1, frac=~x.
    int          eng_cnt = 0;
    logic [15:0] eng_op  = 16'h0000;
    always @(posedge clk) begin
        if (eng_start) begin
            eng_done <= 1'b0;
            eng_cnt  <= 10;
            eng_op   <= eng_x;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                eng_done <= 1'b1;
                eng_int  <= 2'b01;
                eng_frac <= ~eng_op;
            end
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic        id;
        logic [1:0]  int_v;
        logic [15:0] frac;
        logic        err;
    } res_t;

    res_t sb_q[$];
    res_t mon_e;
    int   jobs      = 0;
    int   start_cnt = 0;

    task automatic push_res(input logic id, input logic [15:0] x);
        res_t r;
        r.id    = id;
        r.int_v = 2'b01;
        r.frac  = ~x;
        r.err   = 1'b0;
        sb_q.push_back(r);
        jobs++;
    endtask

    // Result monitor: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && eng_start) start_cnt <= start_cnt + 1;
        if (!rst && out_valid && out_ack) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_result: got id=%0d frac=%h with no job pending",
                         out_id, out_frac);
            end else begin
                mon_e = sb_q.pop_front();
                $display("result id=%0d int=%0d frac=%h err=%0d", out_id, out_int, out_frac, out_err);
                chk("res_id",   {31'd0, out_id},   {31'd0, mon_e.id});
                chk("res_int",  {30'd0, out_int},  {30'd0, mon_e.int_v});
                chk("res_frac", {16'd0, out_frac}, {16'd0, mon_e.frac});
                chk("res_err",  {31'd0, out_err},  {31'd0, mon_e.err});
            end
        end
    end

    // Inputs change and outputs are checked 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (gnt0) req0 = 1'b0;
        if (gnt1) req1 = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk({name, "_drained"}, sb_q.size(), 0);
        step();
    endtask

    typedef struct {
        logic        r0;
        logic        r1;
        logic [15:0] x0;
        logic [15:0] x1;
        logic        first;
    } vec_t;

    vec_t tbl[8];
    int   lat;
    int   s0;

    initial begin
        // expected winner follows from the pointer left by the tie sequence (last=1)
        tbl[0] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 16'h1234, 16'hABCD, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 16'h5A5A, 16'hA5A5, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 16'h7FFF, 16'h0000, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 16'h0F0F, 16'h0000, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 1'b1};

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; x0 = '0; x1 = '0; out_ack = 1'b1;
        t_req0 = 1'b0; t_req1 = 1'b0; t_x0 = '0; t_x1 = '0; t_ack = 1'b0; t_eng_done = 1'b0;
        step(); step();

        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_x", eng_x, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_int", out_int, 0);
        chk("rst_out_frac", out_frac, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_to_valid", t_out_valid, 0);
        rst = 1'b0;
        step();

        // single job, including latency through SETTLE and the done-low window
        x0 = 16'h8000; req0 = 1'b1; push_res(1'b0, 16'h8000);
        step();
        chk("single_gnt0", gnt0, 1);
        chk("single_gnt1", gnt1, 0);
        chk("single_start", eng_start, 1);
        chk("single_eng_x", eng_x, 16'h8000);
        lat = 0;
        while (!out_valid && lat < 40) begin step(); lat++; end
        chk("single_latency", lat, 12);
        drain("single", 5);

        // tie after reset: requester 0 first, then 1; next tie again 0 first
        rst = 1'b1; sb_q.delete(); step(); rst = 1'b0; step();
        x0 = 16'hCCCC; x1 = 16'h3333; req0 = 1'b1; req1 = 1'b1;
        push_res(1'b0, 16'hCCCC); push_res(1'b1, 16'h3333);
        drain("tie1", 80);
        x0 = 16'h0F00; x1 = 16'h00F0; req0 = 1'b1; req1 = 1'b1;
        push_res(1'b0, 16'h0F00); push_res(1'b1, 16'h00F0);
        drain("tie2", 80);

        // table of request patterns
        for (int i = 0; i < 8; i++) begin
            x0 = tbl[i].x0; x1 = tbl[i].x1; req0 = tbl[i].r0; req1 = tbl[i].r1;
            if (tbl[i].r0 && tbl[i].r1) begin
                push_res(tbl[i].first, tbl[i].first ? tbl[i].x1 : tbl[i].x0);
                push_res(~tbl[i].first, tbl[i].first ? tbl[i].x0 : tbl[i].x1);
            end else begin
                push_res(tbl[i].first, tbl[i].first ? tbl[i].x1 : tbl[i].x0);
            end
            drain($sformatf("vec%0d", i), 80);
        end

        // backpressure: result held 20 cycles, late req1 ignored until IDLE
        out_ack = 1'b0; x0 = 16'h0042; req0 = 1'b1; push_res(1'b0, 16'h0042);
        lat = 0;
        while (!out_valid && lat < 40) begin step(); lat++; end
        chk("bp_reach_result", out_valid, 1);
        s0 = start_cnt;
        x1 = 16'h7777; req1 = 1'b1; push_res(1'b1, 16'h7777);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("bp_valid_held", out_valid, 1);
            chk("bp_frac_held", out_frac, 16'hFFBD);
            chk("bp_id_held", out_id, 0);
        end
        chk("bp_no_restart", start_cnt, s0);
        out_ack = 1'b1;
        step();
        chk("bp_idle_valid", out_valid, 0);
        chk("bp_idle_gnt1", gnt1, 0);
        step();
        chk("bp_gnt1_2cyc", gnt1, 1);
        chk("bp_start_2cyc", eng_start, 1);
        chk("bp_eng_x", eng_x, 16'h7777);
        drain("bp", 80);

        // reset during WAIT aborts the job silently
        x0 = 16'h5555; req0 = 1'b1; jobs++;
        step();
        chk("abort_gnt0", gnt0, 1);
        step(); step(); step();
        rst = 1'b1;
        step();
        chk("abort_gnt0_rst", gnt0, 0);
        chk("abort_start_rst", eng_start, 0);
        chk("abort_eng_x_rst", eng_x, 0);
        chk("abort_valid_rst", out_valid, 0);
        chk("abort_int_rst", out_int, 0);
        chk("abort_frac_rst", out_frac, 0);
        chk("abort_err_rst", out_err, 0);
        rst = 1'b0;
        step();
        x0 = 16'h0A0A; req0 = 1'b1; push_res(1'b0, 16'h0A0A);
        step();
        chk("post_rst_gnt0", gnt0, 1);
        drain("post_rst", 80);
        chk("start_count", start_cnt, jobs);

        // timeout instance: done never rises
        t_ack = 1'b0; t_x0 = 16'h9999; t_req0 = 1'b1;
        step();
        chk("to_gnt0", t_gnt0, 1);
        t_req0 = 1'b0;
        lat = 0;
        while (!t_out_valid && lat < 40) begin step(); lat++; end
        chk("to_latency", lat, 10);
        chk("to_err", t_out_err, 1);
        chk("to_int", t_out_int, 0);
        chk("to_frac", t_out_frac, 0);
        chk("to_id", t_out_id, 0);
        $display("result(timeout) id=%0d int=%0d frac=%h err=%0d", t_out_id, t_out_int, t_out_frac, t_out_err);
        t_ack = 1'b1;
        step();
        chk("to_ack_idle", t_out_valid, 0);
        t_ack = 1'b0;

        // done arriving on the very cycle the counter expires wins
        t_req0 = 1'b1;
        step();
        chk("prio_gnt0", t_gnt0, 1);
        t_req0 = 1'b0;
        for (int k = 0; k < 9; k++) step();
        t_eng_done = 1'b1;
        step();
        chk("prio_valid", t_out_valid, 1);
        chk("prio_err", t_out_err, 0);
        chk("prio_int", t_out_int, 2'b11);
        chk("prio_frac", t_out_frac, 16'hBEEF);
        $display("result(prio) id=%0d int=%0d frac=%h err=%0d", t_out_id, t_out_int, t_out_frac, t_out_err);
        t_eng_done = 1'b0; t_ack = 1'b1;
        step(); step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
